hazard_scoreboard: RTL and testbench

//  Parametrised per-register scoreboard for operand hazards. Generalises the single-load-use interlock to
//  N-cycle producers and multi-cycle (long) units, and adds WAW checking.

---
 rtl/hazard_scoreboard_pkg.sv | 13 +
 rtl/hazard_sb_entry.sv | 31 +++
 rtl/hazard_scoreboard.sv | 98 +++++++++
 tb/tb_hazard_scoreboard.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: shared constants, stall-cause type and LONG-code helper
// for the operand hazard scoreboard.
package hazard_scoreboard_pkg;

   localparam int HZ_MAX_LAT = 4;

   typedef enum logic [2:0] {HZ_NONE, HZ_STICKY, HZ_RAW1, HZ_RAW2, HZ_WAW} hz_cause_e;

   function automatic logic [7:0] hz_lat_long(input int width);
      return 8'((1 << width) - 1);
   endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// hazard_sb_entry: one register's pending counter; loads on issue, counts fixed
// latencies down unless held, and parks LONG entries until their writeback.
module hazard_sb_entry
   import hazard_scoreboard_pkg::*;
#(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             issue,
   input  logic             hold,
   input  logic             wb_clr,
   input  logic [CNT_W-1:0] lat,
   output logic [CNT_W-1:0] cnt
);

   localparam logic [CNT_W-1:0] LONG = CNT_W'(hz_lat_long(CNT_W));

   logic [CNT_W-1:0] cnt_nxt;

   // issue takes priority over both the decrement and the writeback clear
   always_comb
      cnt_nxt = issue ? lat :
                (cnt == LONG) ? (wb_clr ? '0 : cnt) :
                (cnt != '0 && !hold) ? cnt - 1'b1 : cnt;

   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt <= '0;
      else      cnt <= cnt_nxt;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register operand hazard scoreboard (RAW, WAW, sticky stall).
// Optional stall statistics with HAZARD_STATS_EN; simulation checks with SIM.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int MAX_LAT  = HZ_MAX_LAT,
   parameter int CNT_W    = $clog2(MAX_LAT + 2)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid_i,
   input  logic [4:0]       rs1_i,
   input  logic [4:0]       rs2_i,
   input  logic             rs1_used_i,
   input  logic             rs2_used_i,
   input  logic [4:0]       rd_i,
   input  logic             rd_we_i,
   input  logic [CNT_W-1:0] issue_lat_i,
   input  logic             hold_i,
   input  logic             wb_done_i,
   input  logic [4:0]       wb_rd_i,
   input  logic             ext_stall_req_i,
   input  logic             unstall_i,
   output logic             stall_o,
   output logic             sticky_o,
   output logic             busy_o,
   output logic [31:0]      stall_cnt_o
);

   logic [CNT_W-1:0]    cnt [NUM_REGS];
   logic [NUM_REGS-1:0] pend;
   logic                sticky_nxt, hazard, issue;

   assign cnt[0] = '0;

   for (genvar g = 1; g < NUM_REGS; g++) begin : g_ent
      hazard_sb_entry #(.CNT_W(CNT_W)) u_ent (
         .clk    (clk),
         .rst    (rst),
         .issue  (issue && rd_i == 5'(g)),
         .hold   (hold_i),
         .wb_clr (wb_done_i && wb_rd_i == 5'(g)),
         .lat    (issue_lat_i),
         .cnt    (cnt[g])
      );
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_pend
      assign pend[g] = cnt[g] != '0;
   end

   // the rd term is the WAW check, so a pending entry is never overwritten
   assign hazard     = id_valid_i && ((rs1_used_i && pend[rs1_i]) ||
                                      (rs2_used_i && pend[rs2_i]) ||
                                      (rd_we_i    && pend[rd_i]));
   assign sticky_nxt = (sticky_o || ext_stall_req_i) && !unstall_i;
   assign stall_o    = sticky_nxt || hazard;
   assign issue      = id_valid_i && !stall_o && rd_we_i && rd_i != '0 && issue_lat_i != '0;
   assign busy_o     = |pend;

   always_ff @(posedge clk or negedge rst)
      if (!rst) sticky_o <= 1'b0;
      else      sticky_o <= sticky_nxt;

`ifdef HAZARD_STATS_EN
   always_ff @(posedge clk or negedge rst)
      if (!rst)                             stall_cnt_o <= '0;
      else if (stall_o && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 32'd1;
`ifdef SIM
   logic      stall_q;
   hz_cause_e cause;
   always_comb
      cause = sticky_nxt ? HZ_STICKY :
              !id_valid_i ? HZ_NONE :
              (rs1_used_i && pend[rs1_i]) ? HZ_RAW1 :
              (rs2_used_i && pend[rs2_i]) ? HZ_RAW2 :
              (rd_we_i && pend[rd_i]) ? HZ_WAW : HZ_NONE;
   always_ff @(posedge clk or negedge rst)
      if (!rst) stall_q <= 1'b0;
      else      stall_q <= stall_o;
   always_ff @(posedge clk)
      if (rst && stall_o && !stall_q)
         $display("hazard_scoreboard: stall start, cause %s", cause.name());
`endif
`else
   assign stall_cnt_o = '0;
`endif

`ifdef SIM
   localparam logic [CNT_W-1:0] LAT_LONG = CNT_W'(hz_lat_long(CNT_W));
   always_ff @(posedge clk)
      if (rst && id_valid_i && rd_we_i)
         assert (issue_lat_i <= CNT_W'(MAX_LAT) || issue_lat_i == LAT_LONG)
            else $error("hazard_scoreboard: illegal issue latency %0d", issue_lat_i);
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios plus randomized traffic checked against
// a per-register remaining-cycles model of the scoreboard.
module tb_hazard_scoreboard;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        id_valid_i, rs1_used_i, rs2_used_i, rd_we_i, hold_i, wb_done_i;
   logic        ext_stall_req_i, unstall_i;
   logic [4:0]  rs1_i, rs2_i, rd_i, wb_rd_i;
   logic [2:0]  issue_lat_i;
   logic        stall_o, sticky_o, busy_o;
   logic [31:0] stall_cnt_o;

   int          n_chk = 0, n_fail = 0;
   int          rem [32];
   bit          lng [32];
   bit          m_sticky, last_stall;
   logic [31:0] m_cnt;

   hazard_scoreboard dut (
      .clk(clk), .rst(rst), .id_valid_i(id_valid_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
      .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i), .rd_i(rd_i), .rd_we_i(rd_we_i),
      .issue_lat_i(issue_lat_i), .hold_i(hold_i), .wb_done_i(wb_done_i), .wb_rd_i(wb_rd_i),
      .ext_stall_req_i(ext_stall_req_i), .unstall_i(unstall_i), .stall_o(stall_o),
      .sticky_o(sticky_o), .busy_o(busy_o), .stall_cnt_o(stall_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit mpend(input int r);
      return r != 0 && (lng[r] || rem[r] != 0);
   endfunction

   task automatic clear_model();
      foreach (rem[r]) begin rem[r] = 0; lng[r] = 0; end
      m_sticky = 0;
      m_cnt    = '0;
   endtask

   task automatic idle();
      id_valid_i = 0; rs1_used_i = 0; rs2_used_i = 0; rd_we_i = 0; hold_i = 0;
      wb_done_i = 0; ext_stall_req_i = 0; unstall_i = 0;
      rs1_i = 0; rs2_i = 0; rd_i = 0; wb_rd_i = 0; issue_lat_i = 0;
   endtask

   task automatic set_issue(input int rd, input int lat);
      idle();
      id_valid_i = 1; rd_we_i = 1; rd_i = 5'(rd); issue_lat_i = 3'(lat);
   endtask

   // one cycle: check outputs against the model for the current inputs, then advance the model
   task automatic step();
      bit          sn, hz, st, bz;
      logic [31:0] exp_cnt;
      sn = (m_sticky || ext_stall_req_i) && !unstall_i;
      hz = id_valid_i && ((rs1_used_i && mpend(rs1_i)) || (rs2_used_i && mpend(rs2_i)) ||
                          (rd_we_i && mpend(rd_i)));
      st = sn || hz;
      bz = 0;
      for (int r = 0; r < 32; r++) bz |= mpend(r);
`ifdef HAZARD_STATS_EN
      exp_cnt = m_cnt;
`else
      exp_cnt = '0;
`endif
      #1;
      chk("stall_o", 32'(stall_o), 32'(st));
      chk("sticky_o", 32'(sticky_o), 32'(m_sticky));
      chk("busy_o", 32'(busy_o), 32'(bz));
      chk("stall_cnt_o", stall_cnt_o, exp_cnt);
      last_stall = stall_o;
      for (int r = 1; r < 32; r++)
         if (lng[r]) begin
            if (wb_done_i && wb_rd_i == 5'(r)) lng[r] = 0;
         end else if (rem[r] > 0 && !hold_i) rem[r]--;
      if (id_valid_i && !st && rd_we_i && rd_i != 0 && issue_lat_i != 0) begin
         lng[rd_i] = issue_lat_i == 3'd7;
         rem[rd_i] = issue_lat_i == 3'd7 ? 0 : int'(issue_lat_i);
      end
      m_sticky = sn;
      if (st && m_cnt != '1) m_cnt++;
      @(negedge clk);
   endtask

   initial begin
      int stalls, pick;
      idle();
      clear_model();
      @(posedge clk);
      #1;
      chk("rst_stall", 32'(stall_o), 0);
      chk("rst_busy", 32'(busy_o), 0);
      chk("rst_sticky", 32'(sticky_o), 0);
      chk("rst_cnt", stall_cnt_o, 0);
      @(negedge clk);
      rst = 1;
      step();

      // load-use: one bubble
      set_issue(5, 1); step();
      idle(); id_valid_i = 1; rs1_used_i = 1; rs1_i = 5;
      step(); chk("lu_bubble", 32'(last_stall), 1);
      step(); chk("lu_release", 32'(last_stall), 0);

      // lat 3 with two hold cycles: five stalled cycles
      set_issue(7, 3); step();
      idle(); id_valid_i = 1; rs2_used_i = 1; rs2_i = 7;
      stalls = 0;
      for (int i = 0; i < 8; i++) begin
         hold_i = i == 1 || i == 2;
         step();
         stalls += int'(last_stall);
      end
      chk("lat3_hold_stalls", 32'(stalls), 5);

      // LONG: wrong writeback ignored, right one releases next cycle
      set_issue(9, 7); step();
      idle(); id_valid_i = 1; rs1_used_i = 1; rs1_i = 9;
      stalls = 0;
      for (int i = 0; i < 6; i++) begin
         wb_done_i = i == 3; wb_rd_i = 8;
         step();
         stalls += int'(last_stall);
      end
      chk("long_stalls", 32'(stalls), 6);
      wb_done_i = 1; wb_rd_i = 9; step();
      chk("long_wb_cycle", 32'(last_stall), 1);
      wb_done_i = 0; step();
      chk("long_release", 32'(last_stall), 0);

      // WAW: second writer to rd=4 waits for the first
      set_issue(4, 2); step();
      set_issue(4, 1);
      stalls = 0;
      for (int i = 0; i < 10 && (i == 0 || last_stall); i++) begin
         step();
         stalls += int'(last_stall);
      end
      chk("waw_stalls", 32'(stalls), 2);
      idle(); step();
      set_issue(0, 3); step();
      idle(); step();
      chk("rd0_not_busy", 32'(busy_o), 0);

      // sticky: unstall beats same-cycle request, then request holds until unstall
      idle(); ext_stall_req_i = 1; unstall_i = 1; step();
      idle(); step();
      chk("sticky_tie", 32'(sticky_o), 0);
      ext_stall_req_i = 1; step();
      idle();
      stalls = 0;
      for (int i = 0; i < 3; i++) begin step(); stalls += int'(last_stall); end
      chk("sticky_hold", 32'(stalls), 3);
      unstall_i = 1; step();
      chk("sticky_release", 32'(last_stall), 0);
      idle(); step();

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         id_valid_i      = $urandom_range(0, 3) != 0;
         rs1_i           = 5'($urandom_range(0, 7));
         rs2_i           = 5'($urandom_range(0, 7));
         rd_i            = 5'($urandom_range(0, 7));
         rs1_used_i      = 1'($urandom);
         rs2_used_i      = 1'($urandom);
         rd_we_i         = 1'($urandom);
         pick            = $urandom_range(0, 5);
         issue_lat_i     = pick == 5 ? 3'd7 : 3'(pick);
         hold_i          = $urandom_range(0, 3) == 0;
         wb_done_i       = $urandom_range(0, 2) == 0;
         wb_rd_i         = 5'($urandom_range(0, 7));
         ext_stall_req_i = $urandom_range(0, 15) == 0;
         unstall_i       = $urandom_range(0, 3) == 0;
         step();
         if (i == 700) begin
            set_issue(3, 7); step();
            idle(); ext_stall_req_i = 1;
            #2 rst = 0;
            #1;
            chk("midrst_busy", 32'(busy_o), 0);
            chk("midrst_sticky", 32'(sticky_o), 0);
            chk("midrst_cnt", stall_cnt_o, 0);
            clear_model();
            idle();
            @(negedge clk);
            rst = 1;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
